fir_drive_ctrl: RTL and testbench

//  Host-side initiator for the fir_filter load/sample interface, in the clk_fast domain.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_slot_timer.sv | 16 +
 rtl/fir_drive_ctrl.sv | 80 ++++++++
 tb/tb_fir_drive_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, state encoding and bus typedefs for fir_filter and its drivers
package fir_pkg;
  localparam int DEF_DIN_W    = 16;
  localparam int DEF_COEF_W   = 20;
  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_NUM_COEF = 2048;
  localparam int DEF_RATIO    = 10;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  typedef logic [DEF_ADDR_W-1:0] caddr_t;
  typedef logic [DEF_COEF_W-1:0] cin_t;
  typedef logic [DEF_DIN_W-1:0]  din_t;
endpackage

// File: rtl/fir_slot_timer.sv
// fir_slot_timer: free-running 0..RATIO-1 counter, slot_hit on the last count
// ports: clk_fast clock, resetn async active-low reset, slot_hit one cycle per RATIO
module fir_slot_timer import fir_pkg::*; #(
  parameter int RATIO = DEF_RATIO
) (
  input  logic clk_fast,
  input  logic resetn,
  output logic slot_hit
);
  localparam int CW = $clog2(RATIO);
  logic [CW-1:0] cnt;
  assign slot_hit = cnt == CW'(RATIO - 1);
  always_ff @(posedge clk_fast or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= slot_hit ? '0 : cnt + CW'(1);
endmodule

// File: rtl/fir_drive_ctrl.sv
// fir_drive_ctrl: loads NUM_COEF taps then streams samples into fir_filter, one transfer per slot
// ports: start_load restarts the load; coef_*/smp_* are ready/valid upstream streams;
//        CIN/CADDR/CLOAD write taps, din/valid_in carry samples; load_done, underrun are status
module fir_drive_ctrl import fir_pkg::*; #(
  parameter int DIN_W    = DEF_DIN_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_COEF = DEF_NUM_COEF,
  parameter int RATIO    = DEF_RATIO
) (
  input  logic              clk_fast,
  input  logic              resetn,
  input  logic              start_load,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  input  logic              smp_valid,
  input  logic [DIN_W-1:0]  smp_data,
  output logic              smp_ready,
  output logic [COEF_W-1:0] CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic [DIN_W-1:0]  din,
  output logic              valid_in,
  output logic              load_done,
  output logic              underrun
);
  if (RATIO < 2 || NUM_COEF < 1 || NUM_COEF > (1 << ADDR_W)) begin : g_bad_params
    $error("fir_drive_ctrl: RATIO must be >= 2 and NUM_COEF within 1..2**ADDR_W");
  end
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, caddr_n;
  logic [COEF_W-1:0] cin_n;
  logic [DIN_W-1:0] din_n;
  logic slot_hit, coef_acc, smp_acc, last, done_n, cload_n, vin_n, und_n;
  fir_slot_timer #(.RATIO(RATIO)) u_timer (
    .clk_fast(clk_fast),
    .resetn(resetn),
    .slot_hit(slot_hit)
  );
  // start_load wins over a coinciding slot so a restart never also accepts a word
  always_comb begin
    coef_ready = state == LOAD && slot_hit && !start_load;
    smp_ready  = state == STREAM && slot_hit && !start_load;
    coef_acc   = coef_ready && coef_valid;
    smp_acc    = smp_ready && smp_valid;
    last       = addr == ADDR_W'(NUM_COEF - 1);
    state_n    = start_load ? LOAD : (coef_acc && last) ? STREAM : state;
    addr_n     = start_load ? '0 : (coef_acc && !last) ? addr + ADDR_W'(1) : addr;
    done_n     = start_load ? 1'b0 : (coef_acc && last) ? 1'b1 : load_done;
    cin_n      = coef_acc ? coef_data : CIN;
    caddr_n    = coef_acc ? addr : CADDR;
    din_n      = smp_acc ? smp_data : din;
    cload_n    = coef_acc;
    vin_n      = coef_acc || smp_acc;
    und_n      = smp_ready && !smp_valid;
  end
  always_ff @(posedge clk_fast or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      addr      <= '0;
      load_done <= 1'b0;
      CIN       <= '0;
      CADDR     <= '0;
      din       <= '0;
      CLOAD     <= 1'b0;
      valid_in  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      load_done <= done_n;
      CIN       <= cin_n;
      CADDR     <= caddr_n;
      din       <= din_n;
      CLOAD     <= cload_n;
      valid_in  <= vin_n;
      underrun  <= und_n;
    end
endmodule

// File: tb/tb_fir_drive_ctrl.sv
// tb_fir_drive_ctrl: randomized scoreboard bench for fir_drive_ctrl against a slot-level model
module tb_fir_drive_ctrl;
  localparam int DIN_W = 16, COEF_W = 20, ADDR_W = 11, NUM_COEF = 4, RATIO = 10;
  localparam int M_IDLE = 0, M_LOAD = 1, M_STREAM = 2;
  localparam int K_COEF = 0, K_SMP = 1, K_UND = 2;
  logic clk = 1'b0, resetn = 1'b0, start_load = 1'b0, coef_valid = 1'b0, smp_valid = 1'b0;
  logic [COEF_W-1:0] coef_data = '0;
  logic [DIN_W-1:0] smp_data = '0;
  logic coef_ready, smp_ready, CLOAD, valid_in, load_done, underrun;
  logic [COEF_W-1:0] CIN;
  logic [ADDR_W-1:0] CADDR;
  logic [DIN_W-1:0] din;
  typedef struct {
    int kind;
    int cyc;
    logic [COEF_W-1:0] cin;
    logic [ADDR_W-1:0] caddr;
    logic [DIN_W-1:0] din;
    bit done;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  int ph = 0, m_mode = M_IDLE, m_addr = 0, m_nsmp = 0;
  bit m_done = 0;
  logic [COEF_W-1:0] m_cin = '0;
  logic [ADDR_W-1:0] m_caddr = '0;
  logic [DIN_W-1:0] m_din = '0;
  fir_drive_ctrl #(.DIN_W(DIN_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .NUM_COEF(NUM_COEF), .RATIO(RATIO)) dut (
    .clk_fast(clk), .resetn(resetn), .start_load(start_load),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD), .din(din), .valid_in(valid_in),
    .load_done(load_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_CIN"}, 32'(CIN), 0);
    chk({tag, "_CADDR"}, 32'(CADDR), 0);
    chk({tag, "_din"}, 32'(din), 0);
    chk({tag, "_strobes"}, {29'd0, CLOAD, valid_in, underrun}, 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_ready"}, {30'd0, coef_ready, smp_ready}, 0);
  endtask
  // one clk_fast cycle: drive inputs, check readies, predict the transfer of the coming edge
  task automatic step(bit sl, bit cv, logic [COEF_W-1:0] cd, bit sv, logic [DIN_W-1:0] sd);
    bit hit;
    exp_t e;
    @(negedge clk);
    chk("load_done", 32'(load_done), 32'(m_done));
    start_load = sl; coef_valid = cv; coef_data = cd; smp_valid = sv; smp_data = sd;
    #1;
    hit = ph == RATIO - 1;
    chk("coef_ready", 32'(coef_ready), 32'(m_mode == M_LOAD && hit && !sl));
    chk("smp_ready", 32'(smp_ready), 32'(m_mode == M_STREAM && hit && !sl));
    if (sl) begin
      m_mode = M_LOAD; m_addr = 0; m_done = 0;
    end else if (hit && m_mode == M_LOAD && cv) begin
      m_cin = cd; m_caddr = ADDR_W'(m_addr);
      if (m_addr == NUM_COEF - 1) begin m_mode = M_STREAM; m_done = 1; end
      else m_addr++;
      e = '{K_COEF, cyc + 1, m_cin, m_caddr, m_din, m_done};
      q.push_back(e);
    end else if (hit && m_mode == M_STREAM) begin
      if (sv) begin m_din = sd; m_nsmp++; end
      e = '{sv ? K_SMP : K_UND, cyc + 1, m_cin, m_caddr, m_din, m_done};
      q.push_back(e);
    end
    ph = (ph + 1) % RATIO;
  endtask
  task automatic model_reset();
    q.delete();
    ph = 0; m_mode = M_IDLE; m_addr = 0; m_done = 0;
    m_cin = '0; m_caddr = '0; m_din = '0;
  endtask
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (CLOAD || valid_in || underrun) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe at cycle %0d: CLOAD=%0b valid_in=%0b underrun=%0b, expected none", cyc, CLOAD, valid_in, underrun);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("CLOAD", 32'(CLOAD), 32'(e.kind == K_COEF));
        chk("valid_in", 32'(valid_in), 32'(e.kind != K_UND));
        chk("underrun", 32'(underrun), 32'(e.kind == K_UND));
        chk("CIN", 32'(CIN), 32'(e.cin));
        chk("CADDR", 32'(CADDR), 32'(e.caddr));
        chk("din", 32'(din), 32'(e.din));
        chk("pulse_load_done", 32'(load_done), 32'(e.done));
      end
    end
  end
  initial begin
    bit skipped;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) step(0, 1, COEF_W'($urandom), 1, DIN_W'($urandom));
    chk_zero("idle");
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 100 && m_mode != M_STREAM; i++) step(0, 1, COEF_W'(100 + m_addr), 0, 0);
    step(1, 1, 0, 0, 0);
    skipped = 0;
    for (int i = 0; i < 100 && m_mode != M_STREAM; i++) begin
      if (m_addr == 2 && ph == RATIO - 1 && !skipped) begin
        skipped = 1;
        step(0, 0, COEF_W'(100 + m_addr), 0, 0);
      end else step(0, 1, COEF_W'(100 + m_addr), 0, 0);
    end
    m_nsmp = 0;
    for (int i = 0; i < 200 && m_nsmp < 10; i++) step(0, 0, 0, 1, DIN_W'(m_nsmp));
    for (int i = 0; i < 40; i++) step(0, 0, 0, !(i >= 10 && i < 20), DIN_W'(m_nsmp));
    while (ph != RATIO - 1) step(0, 0, 0, 1, DIN_W'($urandom));
    step(1, 1, COEF_W'($urandom), 1, DIN_W'($urandom));
    for (int i = 0; i < 100 && m_mode != M_STREAM; i++) step(0, 1, COEF_W'($urandom), 1, DIN_W'($urandom));
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, COEF_W'($urandom),
           $urandom_range(0, 3) != 0, DIN_W'($urandom));
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 100 && !(m_addr == 2 && ph == 3); i++) step(0, 1, COEF_W'($urandom), 0, 0);
    #3;
    resetn = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 25; i++) step(0, 1, COEF_W'($urandom), 1, DIN_W'($urandom));
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 100 && m_mode != M_STREAM; i++) step(0, 1, COEF_W'(200 + m_addr), 1, 0);
    for (int i = 0; i < 2 * RATIO; i++) step(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
